hpu_if_ibuf_mq: RTL

Multi-lane instruction buffer between fetch and decode. It accepts up to WR_LANES fetched instructions per cycle under an arbitrary enable mask, and compacts them in lane order into a circular store. It presents up to RD_LANES oldest instructions per cycle to decode under a per-lane valid/ready handshake. It generalises the two-lane, single-issue ibuf to N-write/M-read operation and adds an occupancy output and overflow detection.

---
 rtl/hpu_pkg.sv | 14 +
 rtl/hpu_if_ibuf_compact.sv | 27 ++
 rtl/hpu_if_ibuf_mq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hpu_pkg.sv
// Shared HPU front-end types and the default sizing of the instruction buffer.
package hpu_pkg;

  typedef logic [31:0] if_inst_t;

  localparam int IBUF_WR_LANES = 4;
  localparam int IBUF_RD_LANES = 2;
  localparam int IBUF_DEPTH    = 16;
  localparam int IBUF_CNT_W    = $clog2(IBUF_DEPTH) + 1;

  // Wrap flag in the MSB, slot index below it.
  typedef logic [IBUF_CNT_W-1:0] ibuf_ptr_t;

endpackage

// File: rtl/hpu_if_ibuf_compact.sv
// Lane compactor: exclusive prefix-sum of the enable mask gives each enabled
// lane its offset from the write pointer; the total is the group size.
module hpu_if_ibuf_compact #(
  parameter  int LANES = 4,
  localparam int OFF_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]            en_i,
  output logic [LANES-1:0][OFF_W-1:0] off_o,
  output logic [LANES-1:0]            slot_en_o,
  output logic [OFF_W-1:0]            num_o
);

  logic [OFF_W-1:0] acc_s;

  // Running count of enabled lanes below each lane.
  always_comb begin
    acc_s = '0;
    for (int l = 0; l < LANES; l++) begin
      off_o[l] = acc_s;
      acc_s    = acc_s + OFF_W'(en_i[l]);
    end
    num_o = acc_s;
  end

  assign slot_en_o = en_i;

endmodule

// File: rtl/hpu_if_ibuf_mq.sv
// Multi-lane instruction buffer: compacted N-wide writes from fetch into a
// circular store, M-wide in-order reads to decode with leading-run consumption.
module hpu_if_ibuf_mq
  import hpu_pkg::*;
#(
  parameter  int WR_LANES     = IBUF_WR_LANES,
  parameter  int RD_LANES     = IBUF_RD_LANES,
  parameter  int DEPTH        = IBUF_DEPTH,
  parameter  int AFULL_MARGIN = 2 * WR_LANES + 1,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_en_i,
  input  if_inst_t [WR_LANES-1:0]       ibuf_inst_i,
  input  logic     [WR_LANES-1:0]       ibuf_inst_en_i,
  output logic                          ibuf_afull_o,
  output logic     [CNT_W-1:0]          ibuf_cnt_o,
  output logic                          ibuf_ovf_o,
  output if_inst_t [RD_LANES-1:0]       if_id__inst_o,
  output logic     [RD_LANES-1:0]       if_id__inst_vld_o,
  input  logic     [RD_LANES-1:0]       id_if__inst_rdy_i
);

  localparam int IDX_W = CNT_W - 1;
  localparam int OFF_W = $clog2(WR_LANES + 1);
  localparam int RDN_W = $clog2(RD_LANES + 1);

  typedef logic [CNT_W-1:0] ptr_t;

  ptr_t     wr_ptr_q, wr_ptr_d;
  ptr_t     rd_ptr_q, rd_ptr_d;
  ptr_t     cnt_s, free_s;
  if_inst_t store_q [DEPTH];
  if_inst_t store_d [DEPTH];
  logic     ovf_q, ovf_d;

  logic [WR_LANES-1:0][OFF_W-1:0] off_s;
  logic [WR_LANES-1:0]            slot_en_s;
  logic [OFF_W-1:0]               wr_num_s;
  logic [RDN_W-1:0]               rd_num_s;
  logic                           run_s;

  hpu_if_ibuf_compact #(.LANES(WR_LANES)) u_compact (
    .en_i      (ibuf_inst_en_i),
    .off_o     (off_s),
    .slot_en_o (slot_en_s),
    .num_o     (wr_num_s)
  );

  // Wrap flag makes full (cnt=DEPTH) distinct from empty.
  assign cnt_s        = wr_ptr_q - rd_ptr_q;
  assign free_s       = CNT_W'(DEPTH) - cnt_s;
  assign ibuf_cnt_o   = cnt_s;
  assign ibuf_ovf_o   = ovf_q;
  assign ibuf_afull_o = 32'(free_s) < AFULL_MARGIN;

  // Read window: the oldest RD_LANES slots, wrapping mid-group.
  always_comb begin
    for (int k = 0; k < RD_LANES; k++) begin
      if_id__inst_o[k]     = store_q[IDX_W'(rd_ptr_q + CNT_W'(k))];
      if_id__inst_vld_o[k] = 32'(cnt_s) > k;
    end
  end

  // Only the unbroken run of handshakes from lane 0 is consumed.
  always_comb begin
    run_s    = 1'b1;
    rd_num_s = '0;
    for (int k = 0; k < RD_LANES; k++) begin
      if (run_s && if_id__inst_vld_o[k] && id_if__inst_rdy_i[k]) begin
        rd_num_s = rd_num_s + RDN_W'(1);
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // Space check uses the pre-cycle count; same-cycle reads earn no credit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    store_d  = store_q;
    if (flush_en_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + CNT_W'(rd_num_s);
      if (CNT_W'(wr_num_s) > free_s) begin
        ovf_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + CNT_W'(wr_num_s);
        for (int l = 0; l < WR_LANES; l++) begin
          if (slot_en_s[l]) begin
            store_d[IDX_W'(wr_ptr_q + CNT_W'(off_s[l]))] = ibuf_inst_i[l];
          end else begin
            store_d[IDX_W'(wr_ptr_q + CNT_W'(off_s[l]))] =
              store_d[IDX_W'(wr_ptr_q + CNT_W'(off_s[l]))];
          end
        end
      end
    end
  end

  // State registers; the store is cleared on reset only, never on flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      store_q  <= store_d;
    end
  end

endmodule
